clock_enable_gen: RTL and testbench

//  Parametrised successor to the fixed /8 system-clock strobe generator. Runs on the 16 MHz PLL clock and

---
 rtl/clock_gen_pkg.sv | 14 +
 rtl/clock_enable_gen_if.sv | 25 ++
 rtl/strobe_divider.sv | 47 ++++
 rtl/clock_enable_gen.sv | 128 ++++++++++++
 tb/tb_clock_enable_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/clock_gen_pkg.sv
// Shared defaults, limits and types for the clock_enable_gen CPU/FDC strobe generator.
package clock_gen_pkg;

  localparam int CLK_DIV_W_DEFAULT      = 4;
  localparam int CLK_DIV_DEFAULT        = 8;
  localparam int CLK_PHI2_PHASE_DEFAULT = 0;
  localparam int CLK_FDC_DIV_W_DEFAULT  = 3;

  // Smallest legal divide register value, giving a two-cycle period.
  localparam int MIN_DIV = 1;

  typedef logic [CLK_DIV_W_DEFAULT-1:0] period_cnt_t;

endpackage

// File: rtl/clock_enable_gen_if.sv
// Control and strobe bundle between clock_enable_gen and its CPU/bus/FDC consumers.
interface clock_enable_gen_if #(
  parameter int DIV_W = clock_gen_pkg::CLK_DIV_W_DEFAULT
);

  logic [DIV_W-1:0] div_sel;
  logic             div_load;
  logic             stretch_req;
  logic             stretch_ack;
  logic             phi_0;
  logic             phi_2;
  logic             clk_sel_fdc;
  logic [DIV_W-1:0] period_cnt;

  modport master (
    output div_sel, div_load, stretch_req,
    input  stretch_ack, phi_0, phi_2, clk_sel_fdc, period_cnt
  );

  modport slave (
    input  div_sel, div_load, stretch_req,
    output stretch_ack, phi_0, phi_2, clk_sel_fdc, period_cnt
  );

endinterface

// File: rtl/strobe_divider.sv
// Wrap counter with registered decode of the cycles where the next count is zero or a given phase.
module strobe_divider
  import clock_gen_pkg::*;
#(
  parameter int WIDTH     = CLK_DIV_W_DEFAULT,
  parameter int RESET_CNT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_phase,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_strobe_zero,
  output logic             o_strobe_phase
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic             r_strobe_zero;
  logic             r_strobe_phase;

  always_comb begin
    w_cnt_next = r_cnt;
    if (!i_hold) begin
      w_cnt_next = (r_cnt == i_limit) ? '0 : r_cnt + 1'b1;
    end
  end

  // Strobes are decoded from the next count so they line up with the count they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= WIDTH'(RESET_CNT);
      r_strobe_zero  <= 1'b0;
      r_strobe_phase <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_strobe_zero  <= !i_hold && (w_cnt_next == '0);
      r_strobe_phase <= !i_hold && (w_cnt_next == i_phase);
    end
  end

  assign o_cnt          = r_cnt;
  assign o_strobe_zero  = r_strobe_zero;
  assign o_strobe_phase = r_strobe_phase;

endmodule

// File: rtl/clock_enable_gen.sv
// Programmable CPU strobe generator (phi_0/phi_2) plus free-running FDC rate select.
// Define CLK_STRETCH_EN to build the wait-state stretch handshake; otherwise stretch_ack is tied low.
module clock_enable_gen
  import clock_gen_pkg::*;
#(
  parameter int DIV_W       = CLK_DIV_W_DEFAULT,
  parameter int DIV_DEFAULT = CLK_DIV_DEFAULT,
  parameter int PHI2_PHASE  = CLK_PHI2_PHASE_DEFAULT,
  parameter int FDC_DIV_W   = CLK_FDC_DIV_W_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  clock_enable_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_DEFAULT - 1);
  localparam int               PHASE_MAX = (1 << DIV_W) - 1;
  localparam logic [DIV_W-1:0] PHASE_C   = DIV_W'((PHI2_PHASE > PHASE_MAX) ? PHASE_MAX : PHI2_PHASE);
  localparam logic [DIV_W-1:0] MIN_DIV_C = DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_valid;
  logic [DIV_W-1:0] w_cnt;
  logic [DIV_W-1:0] w_sel_clamped;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_phase;
  logic             w_hold;
  logic             w_wrap;
  logic             w_phi0;
  logic             w_phi2;

`ifdef CLK_STRETCH_EN
  logic r_stretch_ack;

  // A request only counts on the last cycle of a period; the count then sits there until released.
  assign w_hold = (w_cnt == r_div) && bus.stretch_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stretch_ack <= 1'b0;
    end else begin
      r_stretch_ack <= w_hold;
    end
  end

  assign bus.stretch_ack = r_stretch_ack;
`else
  logic w_unused_stretch_req;

  assign w_hold               = 1'b0;
  assign w_unused_stretch_req = bus.stretch_req;
  assign bus.stretch_ack      = 1'b0;
`endif

  assign w_wrap        = (w_cnt == r_div) && !w_hold;
  assign w_sel_clamped = (bus.div_sel < MIN_DIV_C) ? MIN_DIV_C : bus.div_sel;

  // A load landing on the wrap cycle takes effect for the period that wrap starts.
  always_comb begin
    w_div_next = r_div;
    if (w_wrap) begin
      if (bus.div_load) begin
        w_div_next = w_sel_clamped;
      end else if (r_pend_valid) begin
        w_div_next = r_pend_div;
      end
    end
  end

  assign w_phase = (PHASE_C < w_div_next) ? PHASE_C : w_div_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div        <= DIV_RESET;
      r_pend_div   <= DIV_RESET;
      r_pend_valid <= 1'b0;
    end else if (w_wrap) begin
      r_div        <= w_div_next;
      r_pend_valid <= 1'b0;
    end else if (bus.div_load) begin
      r_pend_div   <= w_sel_clamped;
      r_pend_valid <= 1'b1;
    end
  end

  strobe_divider #(
    .WIDTH     (DIV_W),
    .RESET_CNT (DIV_DEFAULT - 1)
  ) u_cpu_div (
    .clk            (clk),
    .reset          (reset),
    .i_limit        (r_div),
    .i_hold         (w_hold),
    .i_phase        (w_phase),
    .o_cnt          (w_cnt),
    .o_strobe_zero  (w_phi0),
    .o_strobe_phase (w_phi2)
  );

  logic [FDC_DIV_W-1:0] w_fdc_cnt;
  logic                 w_fdc_zero;
  logic                 w_fdc_phase;
  logic                 w_unused_fdc;

  // The FDC divider free-runs over its full range; only its MSB is needed.
  strobe_divider #(
    .WIDTH     (FDC_DIV_W),
    .RESET_CNT (0)
  ) u_fdc_div (
    .clk            (clk),
    .reset          (reset),
    .i_limit        ({FDC_DIV_W{1'b1}}),
    .i_hold         (1'b0),
    .i_phase        ({FDC_DIV_W{1'b0}}),
    .o_cnt          (w_fdc_cnt),
    .o_strobe_zero  (w_fdc_zero),
    .o_strobe_phase (w_fdc_phase)
  );

  assign w_unused_fdc = &{1'b0, w_fdc_cnt, w_fdc_zero, w_fdc_phase};

  assign bus.phi_0       = w_phi0;
  assign bus.phi_2       = w_phi2;
  assign bus.clk_sel_fdc = !w_fdc_cnt[FDC_DIV_W-1];
  assign bus.period_cnt  = w_cnt;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: two instances (phi_2 phase 0 and 4) driven with identical stimulus.
module tb_clock_enable_gen;
  import clock_gen_pkg::*;

  localparam int DIV_W = CLK_DIV_W_DEFAULT;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clock_enable_gen_if #(.DIV_W(DIV_W)) busA ();
  clock_enable_gen_if #(.DIV_W(DIV_W)) busB ();

  clock_enable_gen #(
    .DIV_W(DIV_W), .DIV_DEFAULT(8), .PHI2_PHASE(0), .FDC_DIV_W(3)
  ) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  clock_enable_gen #(
    .DIV_W(DIV_W), .DIV_DEFAULT(8), .PHI2_PHASE(4), .FDC_DIV_W(3)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  int testCount = 0;
  int failCount = 0;

  logic [63:0] mPhi0, mPhi2A, mPhi2B, mSel, mAck;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input period_cnt_t sel, input logic load, input logic req);
    busA.div_sel     = sel;
    busA.div_load    = load;
    busA.stretch_req = req;
    busB.div_sel     = sel;
    busB.div_load    = load;
    busB.stretch_req = req;
  endtask

  // Bit i of each mask holds the output seen i cycles after the call; stretch_req is high for the first reqLen cycles.
  task automatic capture(input int n, input int reqLen);
    mPhi0 = '0; mPhi2A = '0; mPhi2B = '0; mSel = '0; mAck = '0;
    for (int i = 0; i < n; i++) begin
      busA.stretch_req = (i < reqLen);
      busB.stretch_req = (i < reqLen);
      mPhi0[i]  = busA.phi_0;
      mPhi2A[i] = busA.phi_2;
      mPhi2B[i] = busB.phi_2;
      mSel[i]   = busA.clk_sel_fdc;
      mAck[i]   = busA.stretch_ack;
      tick();
    end
    busA.stretch_req = 1'b0;
    busB.stretch_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b0);
    tickN(3);
    checkOutput("reset_phi0", 64'(busA.phi_0), 64'd0);
    checkOutput("reset_phi2", 64'(busA.phi_2), 64'd0);
    checkOutput("reset_ack", 64'(busA.stretch_ack), 64'd0);
    checkOutput("reset_fdc", 64'(busA.clk_sel_fdc), 64'd1);
    checkOutput("reset_cnt", 64'(busA.period_cnt), 64'd7);

    // Cycle 0 is the cycle right after reset is released.
    reset = 1'b0;
    capture(32, 0);
    checkOutput("t1_phi0", mPhi0, 64'h0202_0202);
    checkOutput("t1_phi2", mPhi2A, 64'h0202_0202);
    checkOutput("t1_phi2_ph4", mPhi2B, 64'h2020_2020);
    checkOutput("t1_fdc", mSel, 64'h0F0F_0F0F);
    checkOutput("t1_ack", mAck, 64'd0);
    checkOutput("t1_cnt32", 64'(busA.period_cnt), 64'd7);

    tickN(3);
    checkOutput("t2_cnt35", 64'(busA.period_cnt), 64'd2);
    applyStimulus(4'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd3, 1'b0, 1'b0);
    checkOutput("t2_cnt36", 64'(busA.period_cnt), 64'd3);
    capture(24, 0);
    checkOutput("t2_phi0", mPhi0, 64'h0022_2220);
    checkOutput("t2_phi2_ph4", mPhi2B, 64'h0011_1102);
    checkOutput("t2_cnt60", 64'(busA.period_cnt), 64'd3);

    tick();
    checkOutput("t3_phi0_61", 64'(busA.phi_0), 64'd1);
    applyStimulus(4'd5, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd0, 1'b0, 1'b0);
    capture(12, 0);
    checkOutput("t3_clamp_phi0", mPhi0, 64'h554);
    checkOutput("t3_clamp_phi2", mPhi2A, 64'h554);
    checkOutput("t3_clamp_phi2_ph4", mPhi2B, 64'hAAA);
    tick();
    checkOutput("t3_cnt76", 64'(busA.period_cnt), 64'd1);
    applyStimulus(4'd15, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd15, 1'b0, 1'b0);
    capture(40, 0);
    checkOutput("t3_max_phi0", mPhi0, 64'h1_0001_0001);
    checkOutput("t3_max_phi2_ph4", mPhi2B, 64'h10_0010_0010);
    checkOutput("t3_cnt117", 64'(busA.period_cnt), 64'd8);

    applyStimulus(4'd7, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd7, 1'b0, 1'b0);
    tickN(14);
    checkOutput("t4_cnt132", 64'(busA.period_cnt), 64'd7);
`ifdef CLK_STRETCH_EN
    capture(16, 5);
    checkOutput("t4_phi0", mPhi0, 64'h4040);
    checkOutput("t4_phi2", mPhi2A, 64'h4040);
    checkOutput("t4_phi2_ph4", mPhi2B, 64'h400);
    checkOutput("t4_ack", mAck, 64'h3E);
    checkOutput("t6_fdc", mSel, 64'hF0F0);
    tick();
    checkOutput("t4_cnt149", 64'(busA.period_cnt), 64'd3);
    capture(10, 1);
    checkOutput("t4_midreq_phi0", mPhi0, 64'h20);
    checkOutput("t4_midreq_ack", mAck, 64'd0);
    tickN(2);
    checkOutput("t6_cnt161", 64'(busA.period_cnt), 64'd7);
    applyStimulus(4'd7, 1'b0, 1'b1);
    tick();
    checkOutput("t6_ack_a", 64'(busA.stretch_ack), 64'd1);
    tick();
    checkOutput("t6_ack_b", 64'(busA.stretch_ack), 64'd1);
    checkOutput("t6_cnt_held", 64'(busA.period_cnt), 64'd7);
    reset = 1'b1;
    tick();
    checkOutput("t6_rst_ack", 64'(busA.stretch_ack), 64'd0);
`else
    capture(16, 5);
    checkOutput("t4_phi0", mPhi0, 64'h202);
    checkOutput("t4_phi2", mPhi2A, 64'h202);
    checkOutput("t4_phi2_ph4", mPhi2B, 64'h2020);
    checkOutput("t4_ack", mAck, 64'd0);
    checkOutput("t6_fdc", mSel, 64'hF0F0);
    tickN(3);
    checkOutput("t4_cnt151", 64'(busA.period_cnt), 64'd2);
    reset = 1'b1;
    tick();
`endif
    checkOutput("t6_rst_cnt", 64'(busA.period_cnt), 64'd7);
    checkOutput("t6_rst_phi0", 64'(busA.phi_0), 64'd0);
    checkOutput("t6_rst_fdc", 64'(busA.clk_sel_fdc), 64'd1);
    reset = 1'b0;
    applyStimulus(4'd0, 1'b0, 1'b0);
    capture(10, 0);
    checkOutput("t6_rel_phi0", mPhi0, 64'h202);
    checkOutput("t6_rel_phi2", mPhi2A, 64'h202);
    checkOutput("t6_rel_phi2_ph4", mPhi2B, 64'h20);
    checkOutput("t6_rel_fdc", mSel, 64'h30F);
    checkOutput("t6_rel_ack", mAck, 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
